// File: rtl/uart_pkg.sv
// uart_pkg: shared state type and data width for the UART transmit byte buffer
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} txf_state_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: DEPTH x UART_DATA_W register array, one write port, asynchronous read
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int PW = $clog2(DEPTH)
) (
    input  logic                   CLK,
    input  logic                   we,
    input  logic [PW-1:0]          wr_ptr,
    input  logic [UART_DATA_W-1:0] wr_data,
    input  logic [PW-1:0]          rd_ptr,
    output logic [UART_DATA_W-1:0] rd_data
);

    logic [UART_DATA_W-1:0] mem [DEPTH];

    // write port; storage is not reset because reads are only consumed when count says valid
    always_ff @(posedge CLK) if (we) mem[wr_ptr] <= wr_data;

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: circular byte FIFO feeding a UART transmitter, paced on tx_busy.
// Defining UART_TXF_STATUS_EN adds the level and sticky overflow status outputs.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int BUSY_TMO = 8
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [UART_DATA_W-1:0]     wr_data,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    output logic [UART_DATA_W-1:0]     din,
    output logic                       wr_en,
    input  logic                       tx_busy,
    output logic                       empty,
    output logic                       full
`ifdef UART_TXF_STATUS_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       overflow
`endif
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int TW = $clog2(BUSY_TMO + 1);

    txf_state_t             state, state_nxt;
    logic [TW-1:0]          timer, timer_nxt;
    logic [PW-1:0]          rd_ptr, wr_ptr;
    logic [CW-1:0]          count;
    logic [UART_DATA_W-1:0] rd_data;
    logic                   push, pop;

    assign full     = count == CW'(DEPTH);
    assign empty    = count == '0;
    assign wr_ready = ~full;
    assign push     = wr_valid & ~full;
    assign pop      = (state == IDLE) & ~empty & ~tx_busy;
    assign wr_en    = state == LAUNCH;

    uart_fifo_mem #(.DEPTH(DEPTH)) u_mem (
        .CLK     (CLK),
        .we      (push),
        .wr_ptr  (wr_ptr),
        .wr_data (wr_data),
        .rd_ptr  (rd_ptr),
        .rd_data (rd_data)
    );

    // launch sequencing: pop in IDLE, strobe in LAUNCH, then wait for the transmitter (or give up)
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        case (state)
            IDLE:      state_nxt = pop ? LAUNCH : IDLE;
            LAUNCH: begin
                state_nxt = WAIT_BUSY;
                timer_nxt = '0;
            end
            WAIT_BUSY: begin
                if (tx_busy) state_nxt = WAIT_DONE;
                else begin
                    timer_nxt = timer + TW'(1);
                    if (timer_nxt == TW'(BUSY_TMO)) state_nxt = IDLE;
                end
            end
            WAIT_DONE: state_nxt = tx_busy ? WAIT_DONE : IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // FSM state and busy-timeout timer registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            timer <= '0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
        end
    end

    // pointers, occupancy and the byte held on din; a pop never frees room for a same-cycle push
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            din    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
                din    <= rd_data;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

`ifdef UART_TXF_STATUS_EN
    assign level = count;

    // sticky record of any host offer made while the FIFO was full
    always_ff @(posedge CLK) begin
        if (RST) overflow <= 1'b0;
        else if (wr_valid & full) overflow <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed self-checking bench for uart_tx_fifo with a simple transmitter model
module tb_uart_tx_fifo;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] wr_data = 8'h00;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [7:0] din;
    logic       wr_en;
    logic       tx_busy = 1'b0;
    logic       empty;
    logic       full;
`ifdef UART_TXF_STATUS_EN
    logic [4:0] level;
    logic       overflow;
`endif

    int         errors = 0;
    int         checks = 0;
    int         pulses = 0;
    int         busy_viol = 0;
    int         hold = 0;
    int         busy_len = 3;
    bit         pend = 1'b0;
    bit         respond = 1'b1;
    bit         ext_busy = 1'b0;
    logic [7:0] got[$];

    uart_tx_fifo #(.DEPTH(16), .BUSY_TMO(8)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .din      (din),
        .wr_en    (wr_en),
        .tx_busy  (tx_busy),
        .empty    (empty),
        .full     (full)
`ifdef UART_TXF_STATUS_EN
        ,
        .level    (level),
        .overflow (overflow)
`endif
    );

    always #5 CLK = ~CLK;

    // transmitter model: captures each strobe, raises busy one cycle later for busy_len cycles
    initial forever begin
        @(negedge CLK);
        if (pend) begin
            pend = 1'b0;
            hold = busy_len;
        end else if (hold > 0) hold--;
        if (wr_en === 1'b1) begin
            pulses++;
            got.push_back(din);
            if (tx_busy) busy_viol++;
            if (respond) pend = 1'b1;
        end
        tx_busy = ext_busy | (hold > 0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic push(input logic [7:0] b);
        wr_data  = b;
        wr_valid = 1'b1;
        cyc(1);
        wr_valid = 1'b0;
    endtask

    task automatic wait_wr_en(input string tag, input int lim);
        for (int t = 0; t < lim && wr_en !== 1'b1; t++) cyc(1);
        chk(tag, wr_en, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int p0;
        int n;
        // reset held 3 cycles with a pending offer
        wr_data  = 8'h77;
        wr_valid = 1'b1;
        cyc(3);
        RST      = 1'b0;
        wr_valid = 1'b0;
        chk("rst_empty", empty, 1);
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_full", full, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_din", din, 8'h00);
`ifdef UART_TXF_STATUS_EN
        chk("rst_level", level, 0);
        chk("rst_overflow", overflow, 0);
`endif
        cyc(5);
        chk("rst_no_launch", pulses, 0);

        // single byte, two-cycle launch latency
        respond  = 1'b1;
        busy_len = 20;
        push(8'hA5);
        chk("single_wr_en_early", wr_en, 0);
        chk("single_not_empty", empty, 0);
        cyc(1);
        chk("single_wr_en", wr_en, 1);
        chk("single_din", din, 8'hA5);
        chk("single_empty_after_pop", empty, 1);
        cyc(30);
        chk("single_pulses", pulses, 1);
        chk("single_din_hold", din, 8'hA5);

        // burst to full, refused 17th, ordered drain
        got.delete();
        busy_len = 3;
        ext_busy = 1'b1;
        cyc(1);
        wr_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wr_data = 8'(i + 1);
            cyc(1);
        end
        chk("burst_full", full, 1);
        chk("burst_wr_ready", wr_ready, 0);
`ifdef UART_TXF_STATUS_EN
        chk("burst_level", level, 16);
        chk("burst_no_overflow_yet", overflow, 0);
`endif
        wr_data = 8'hEE;
        cyc(1);
        wr_valid = 1'b0;
        chk("burst_still_full", full, 1);
`ifdef UART_TXF_STATUS_EN
        chk("burst_overflow", overflow, 1);
        chk("burst_level_after_refuse", level, 16);
`endif
        ext_busy = 1'b0;
        cyc(150);
        chk("burst_count", got.size(), 16);
        for (int i = 0; i < 16; i++)
            chk("burst_order", (i < got.size()) ? got[i] : 8'h00, 8'(i + 1));
        chk("burst_empty", empty, 1);

        // wrap with simultaneous push and pop at the pop edge
        got.delete();
        busy_len = 1;
        ext_busy = 1'b1;
        cyc(1);
        wr_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_data = 8'(8'h40 + i);
            cyc(1);
        end
        wr_valid = 1'b0;
        ext_busy = 1'b0;
        wait_wr_en("wrap_first_launch", 20);
        for (int i = 4; i < 44; i++) begin
            cyc(3);
            wr_data  = 8'(8'h40 + i);
            wr_valid = 1'b1;
            cyc(1);
            wr_valid = 1'b0;
            chk("wrap_spacing", wr_en, 1);
        end
        chk("wrap_not_empty", empty, 0);
        chk("wrap_not_full", full, 0);
`ifdef UART_TXF_STATUS_EN
        chk("wrap_level", level, 3);
`endif
        cyc(30);
        chk("wrap_count", got.size(), 44);
        for (int i = 0; i < 44; i++)
            chk("wrap_order", (i < got.size()) ? got[i] : 8'h00, 8'(8'h40 + i));
        chk("wrap_empty", empty, 1);

        // busy timeout: transmitter ignores strobes
        got.delete();
        respond = 1'b0;
        p0 = pulses;
        push(8'h5A);
        push(8'hC3);
        wait_wr_en("tmo_first_launch", 10);
        n = 0;
        do begin
            cyc(1);
            n++;
        end while (wr_en !== 1'b1 && n < 30);
        chk("tmo_spacing", n, 10);
        cyc(40);
        chk("tmo_pulses", pulses - p0, 2);
        chk("tmo_first", (got.size() > 0) ? got[0] : 8'h00, 8'h5A);
        chk("tmo_second", (got.size() > 1) ? got[1] : 8'h00, 8'hC3);
        chk("tmo_empty", empty, 1);

        // reset during WAIT_DONE with 5 queued; relaunch waits for busy to clear
        got.delete();
        respond  = 1'b1;
        busy_len = 20;
        ext_busy = 1'b1;
        cyc(1);
        wr_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wr_data = 8'(8'hB0 + i);
            cyc(1);
        end
        wr_valid = 1'b0;
        ext_busy = 1'b0;
        p0 = pulses;
        wait_wr_en("mid_first_launch", 20);
        cyc(3);
        RST = 1'b1;
        cyc(1);
        RST = 1'b0;
        chk("mid_rst_empty", empty, 1);
        chk("mid_rst_wr_ready", wr_ready, 1);
        chk("mid_rst_wr_en", wr_en, 0);
        chk("mid_rst_din", din, 8'h00);
        chk("mid_tx_still_busy", tx_busy, 1);
`ifdef UART_TXF_STATUS_EN
        chk("mid_rst_overflow", overflow, 0);
        chk("mid_rst_level", level, 0);
`endif
        push(8'h3C);
        cyc(3);
        chk("mid_holdoff_wr_en", wr_en, 0);
        chk("mid_holdoff_not_empty", empty, 0);
        chk("mid_holdoff_pulses", pulses - p0, 1);
        cyc(40);
        chk("mid_relaunch_pulses", pulses - p0, 2);
        chk("mid_relaunch_byte", (got.size() > 1) ? got[1] : 8'h00, 8'h3C);
        chk("mid_final_empty", empty, 1);

        chk("no_wr_en_while_busy", busy_viol, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
